// File: rtl/name_hash_table_if.sv
// Request/response bundle between a requester (name hasher side) and the
// name hash table.
//   master : drives req_valid/op/key/hash/data, receives req_ready and the
//            one-cycle response (resp_valid/status/data/index).
//   slave  : the table side of the same signals.
interface name_hash_table_if #(
  parameter int ADDR_W = 10,
  parameter int KEY_W  = 64,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [KEY_W-1:0]  req_key;
  logic [ADDR_W-1:0] req_hash;
  logic [DATA_W-1:0] req_data;
  logic              resp_valid;
  logic [1:0]        resp_status;
  logic [DATA_W-1:0] resp_data;
  logic [ADDR_W-1:0] resp_index;

  modport master (
    output req_valid, req_op, req_key, req_hash, req_data,
    input  req_ready, resp_valid, resp_status, resp_data, resp_index
  );

  modport slave (
    input  req_valid, req_op, req_key, req_hash, req_data,
    output req_ready, resp_valid, resp_status, resp_data, resp_index
  );
endinterface

// File: rtl/name_hash_table.sv
// Open-addressed hash table with linear probing, indexed by a precomputed
// name hash. Supports LOOKUP, INSERT (with payload overwrite on key hit) and
// DELETE (tombstoning). Storage is an internal register array read
// synchronously, one slot per READ/CHECK pair.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset; drops any in-flight request and
//            restarts the table clear
//   tbl_if : slave side of name_hash_table_if (request handshake + response)
module name_hash_table #(
  parameter int ADDR_W    = 10,
  parameter int KEY_W     = 64,
  parameter int DATA_W    = 8,
  parameter int MAX_PROBE = 4
) (
  input  logic              clk,
  input  logic              rst,
  name_hash_table_if.slave  tbl_if
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int KW    = $clog2(MAX_PROBE + 1);

  localparam logic [1:0] OP_LOOKUP = 2'd0;
  localparam logic [1:0] OP_INSERT = 2'd1;
  localparam logic [1:0] OP_DELETE = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  localparam logic [1:0] ST_MISS     = 2'd0;
  localparam logic [1:0] ST_HIT      = 2'd1;
  localparam logic [1:0] ST_INSERTED = 2'd2;
  localparam logic [1:0] ST_FULL     = 2'd3;

  localparam logic [1:0] ENT_EMPTY = 2'd0;
  localparam logic [1:0] ENT_VALID = 2'd1;
  localparam logic [1:0] ENT_TOMB  = 2'd2;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_READ, S_CHECK} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] init_cnt_q;

  logic [1:0]        ent_state_q [DEPTH];
  logic [KEY_W-1:0]  ent_key_q   [DEPTH];
  logic [DATA_W-1:0] ent_data_q  [DEPTH];

  logic [1:0]        op_q;
  logic [KEY_W-1:0]  key_q;
  logic [ADDR_W-1:0] hash_q;
  logic [DATA_W-1:0] data_q;
  logic [KW-1:0]     k_q;
  logic              free_valid_q;
  logic [ADDR_W-1:0] free_idx_q;

  logic [1:0]        rd_state_q;
  logic [KEY_W-1:0]  rd_key_q;
  logic [DATA_W-1:0] rd_data_q;

  logic              resp_valid_q;
  logic [1:0]        resp_status_q;
  logic [DATA_W-1:0] resp_data_q;
  logic [ADDR_W-1:0] resp_index_q;

  logic [ADDR_W-1:0] probe_idx;
  logic              last_probe;
  logic              key_hit;
  logic              slot_free;
  logic [ADDR_W-1:0] free_idx_d;
  logic              done_d;
  logic [1:0]        status_d;
  logic [ADDR_W-1:0] index_d;
  logic              wr_en_d;
  logic [1:0]        wr_state_d;

  assign tbl_if.req_ready   = (state_q == S_IDLE);
  assign tbl_if.resp_valid  = resp_valid_q;
  assign tbl_if.resp_status = resp_status_q;
  assign tbl_if.resp_data   = resp_data_q;
  assign tbl_if.resp_index  = resp_index_q;

  // Decide what the slot fetched in READ means for the current request.
  // The slot address is recomputed from hash+k (k is stable across READ and
  // CHECK), and the index wraps naturally through the ADDR_W-bit add.
  // The free slot to insert into is the first EMPTY/TOMB seen, which may be
  // the slot under examination right now.
  always_comb begin
    probe_idx  = hash_q + ADDR_W'(k_q);
    last_probe = (k_q == KW'(MAX_PROBE - 1));
    key_hit    = (rd_state_q == ENT_VALID) && (rd_key_q == key_q);
    slot_free  = (rd_state_q != ENT_VALID);
    free_idx_d = free_valid_q ? free_idx_q : probe_idx;
    done_d     = 1'b0;
    status_d   = ST_MISS;
    index_d    = '0;
    wr_en_d    = 1'b0;
    wr_state_d = ENT_EMPTY;
    if (op_q == OP_INSERT) begin
      if (key_hit) begin
        done_d     = 1'b1;
        status_d   = ST_HIT;
        index_d    = probe_idx;
        wr_en_d    = 1'b1;
        wr_state_d = ENT_VALID;
      end else if (rd_state_q == ENT_EMPTY) begin
        done_d     = 1'b1;
        status_d   = ST_INSERTED;
        index_d    = free_idx_d;
        wr_en_d    = 1'b1;
        wr_state_d = ENT_VALID;
      end else if (last_probe) begin
        done_d = 1'b1;
        if (free_valid_q || slot_free) begin
          status_d   = ST_INSERTED;
          index_d    = free_idx_d;
          wr_en_d    = 1'b1;
          wr_state_d = ENT_VALID;
        end else begin
          status_d = ST_FULL;
        end
      end
    end else begin
      if (key_hit) begin
        done_d   = 1'b1;
        status_d = ST_HIT;
        index_d  = probe_idx;
        if (op_q == OP_DELETE) begin
          wr_en_d    = 1'b1;
          wr_state_d = ENT_TOMB;
        end
      end else if (rd_state_q == ENT_EMPTY || last_probe) begin
        done_d   = 1'b1;
        status_d = ST_MISS;
      end
    end
  end

  // Table FSM. Reset only restarts the clear sequence; the key/payload
  // arrays need no reset because every slot is marked EMPTY during INIT.
  // Table writes happen only on the edge leaving CHECK, so a reset landing
  // on that edge takes priority and nothing is committed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_INIT;
      init_cnt_q    <= '0;
      op_q          <= OP_LOOKUP;
      key_q         <= '0;
      hash_q        <= '0;
      data_q        <= '0;
      k_q           <= '0;
      free_valid_q  <= 1'b0;
      free_idx_q    <= '0;
      rd_state_q    <= ENT_EMPTY;
      rd_key_q      <= '0;
      rd_data_q     <= '0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= ST_MISS;
      resp_data_q   <= '0;
      resp_index_q  <= '0;
    end else begin
      resp_valid_q  <= 1'b0;
      resp_status_q <= ST_MISS;
      resp_data_q   <= '0;
      resp_index_q  <= '0;
      case (state_q)
        S_INIT: begin
          ent_state_q[init_cnt_q] <= ENT_EMPTY;
          init_cnt_q              <= init_cnt_q + ADDR_W'(1);
          if (init_cnt_q == ADDR_W'(DEPTH - 1)) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (tbl_if.req_valid) begin
            op_q         <= tbl_if.req_op;
            key_q        <= tbl_if.req_key;
            hash_q       <= tbl_if.req_hash;
            data_q       <= tbl_if.req_data;
            k_q          <= '0;
            free_valid_q <= 1'b0;
            // The reserved op never touches the table: answer MISS next cycle.
            if (tbl_if.req_op == OP_RSVD) begin
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= S_READ;
            end
          end
        end
        S_READ: begin
          rd_state_q <= ent_state_q[probe_idx];
          rd_key_q   <= ent_key_q[probe_idx];
          rd_data_q  <= ent_data_q[probe_idx];
          state_q    <= S_CHECK;
        end
        S_CHECK: begin
          if (done_d) begin
            resp_valid_q  <= 1'b1;
            resp_status_q <= status_d;
            resp_index_q  <= index_d;
            resp_data_q   <= (op_q == OP_LOOKUP && status_d == ST_HIT) ? rd_data_q : '0;
            if (wr_en_d) begin
              ent_state_q[index_d] <= wr_state_d;
              if (op_q == OP_INSERT) begin
                ent_key_q[index_d]  <= key_q;
                ent_data_q[index_d] <= data_q;
              end
            end
            state_q <= S_IDLE;
          end else begin
            if (op_q == OP_INSERT && slot_free && !free_valid_q) begin
              free_valid_q <= 1'b1;
              free_idx_q   <= probe_idx;
            end
            k_q     <= k_q + KW'(1);
            state_q <= S_READ;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_name_hash_table.sv
module tb_name_hash_table;
  localparam int ADDR_W    = 10;
  localparam int KEY_W     = 64;
  localparam int DATA_W    = 8;
  localparam int MAX_PROBE = 4;
  localparam int DEPTH     = 1 << ADDR_W;

  localparam logic [1:0] OP_LOOKUP = 2'd0;
  localparam logic [1:0] OP_INSERT = 2'd1;
  localparam logic [1:0] OP_DELETE = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;
  localparam logic [1:0] ST_MISS   = 2'd0;
  localparam logic [1:0] ST_HIT    = 2'd1;
  localparam logic [1:0] ST_INS    = 2'd2;
  localparam logic [1:0] ST_FULL   = 2'd3;

  typedef struct {
    logic [1:0]        op;
    logic [KEY_W-1:0]  key;
    logic [ADDR_W-1:0] hash;
    logic [DATA_W-1:0] data;
    logic [1:0]        st;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] d;
    int                lat;
  } row_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  name_hash_table_if #(.ADDR_W(ADDR_W), .KEY_W(KEY_W), .DATA_W(DATA_W)) tif ();

  name_hash_table #(
    .ADDR_W(ADDR_W), .KEY_W(KEY_W), .DATA_W(DATA_W), .MAX_PROBE(MAX_PROBE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tbl_if (tif)
  );

  // Reference model: the table as plain arrays, 0=empty 1=valid 2=tombstone.
  int                m_state [DEPTH];
  logic [KEY_W-1:0]  m_key   [DEPTH];
  logic [DATA_W-1:0] m_data  [DEPTH];

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_state[i] = 0;
  endtask

  // Walk the probe window, find the key or the first free slot, then apply
  // the operation. Latency is 3 cycles plus 2 per extra slot examined.
  task automatic model_apply(input logic [1:0] op, input logic [KEY_W-1:0] key,
                             input logic [ADDR_W-1:0] hash, input logic [DATA_W-1:0] data,
                             output logic [1:0] st, output logic [ADDR_W-1:0] idx,
                             output logic [DATA_W-1:0] d, output int lat);
    int found = -1;
    int free  = -1;
    int kend  = MAX_PROBE - 1;
    st = ST_MISS; idx = '0; d = '0;
    if (op == OP_RSVD) begin
      lat = 1;
      return;
    end
    for (int k = 0; k < MAX_PROBE; k++) begin
      int s = (int'(hash) + k) % DEPTH;
      if (m_state[s] == 1 && m_key[s] == key) begin found = s; kend = k; break; end
      if (m_state[s] != 1 && free < 0) free = s;
      if (m_state[s] == 0) begin kend = k; break; end
    end
    lat = 3 + 2 * kend;
    if (found >= 0) begin
      st  = ST_HIT;
      idx = ADDR_W'(found);
      if (op == OP_LOOKUP) d = m_data[found];
      if (op == OP_DELETE) m_state[found] = 2;
      if (op == OP_INSERT) m_data[found] = data;
    end else if (op == OP_INSERT) begin
      if (free >= 0) begin
        st = ST_INS;
        idx = ADDR_W'(free);
        m_state[free] = 1; m_key[free] = key; m_data[free] = data;
      end else begin
        st = ST_FULL;
      end
    end
  endtask

  // Present one request (at the current negedge if now=1, else the next
  // one), then wait for its response; lat counts cycles from acceptance.
  task automatic run_req(input bit now, input logic [1:0] op, input logic [KEY_W-1:0] key,
                         input logic [ADDR_W-1:0] hash, input logic [DATA_W-1:0] data,
                         output bit got, output logic [1:0] st, output logic [ADDR_W-1:0] idx,
                         output logic [DATA_W-1:0] d, output int lat);
    int w = 0;
    got = 1'b0; st = '0; idx = '0; d = '0; lat = 0;
    if (!now) @(negedge clk);
    while (!tif.req_ready && w < 3000) begin @(negedge clk); w++; end
    if (!tif.req_ready) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL ready_timeout: req_ready=%0b after %0d cycles, required 1", tif.req_ready, w);
      return;
    end
    tif.req_valid = 1'b1;
    tif.req_op    = op;
    tif.req_key   = key;
    tif.req_hash  = hash;
    tif.req_data  = data;
    @(negedge clk);
    tif.req_valid = 1'b0;
    tif.req_key   = '1;
    lat = 1;
    while (!tif.resp_valid && lat < 20) begin @(negedge clk); lat++; end
    if (tif.resp_valid) begin
      got = 1'b1; st = tif.resp_status; idx = tif.resp_index; d = tif.resp_data;
    end
  endtask

  task automatic test_reset();
    int cnt = 0;
    bit got; logic [1:0] st; logic [ADDR_W-1:0] idx; logic [DATA_W-1:0] d; int lat;
    @(negedge clk);
    n_cmp++;
    if ({tif.req_ready, tif.resp_valid, tif.resp_status, tif.resp_data, tif.resp_index} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: ready=%0b v=%0b st=%0d d=%h idx=%h, required all 0",
               tif.req_ready, tif.resp_valid, tif.resp_status, tif.resp_data, tif.resp_index);
    end
    rst = 1'b0;
    tif.req_valid = 1'b1; tif.req_op = OP_LOOKUP; tif.req_key = 64'h1;
    tif.req_hash = 10'h005; tif.req_data = '0;
    while (!tif.req_ready && cnt < 2000) begin cnt++; @(negedge clk); end
    n_cmp++;
    if (cnt !== 1024) begin
      n_fail++;
      $display("[TB] FAIL init_cycles: ready low for %0d cycles, required 1024", cnt);
    end
    run_req(1'b1, OP_LOOKUP, 64'h1, 10'h005, 8'h00, got, st, idx, d, lat);
    n_cmp++;
    if (!got || st !== ST_MISS || idx !== '0 || d !== '0 || lat !== 3) begin
      n_fail++;
      $display("[TB] FAIL first_lookup: v=%0b st=%0d idx=%h d=%h lat=%0d, required st=0 idx=0 d=0 lat=3",
               got, st, idx, d, lat);
    end
  endtask

  task automatic test_insert_lookup();
    row_t rows[$];
    bit got; logic [1:0] st; logic [ADDR_W-1:0] idx; logic [DATA_W-1:0] d; int lat;
    rows.push_back('{OP_INSERT, 64'hAAAA, 10'h010, 8'h3C, ST_INS, 10'h010, 8'h00, 3});
    rows.push_back('{OP_LOOKUP, 64'hAAAA, 10'h010, 8'h00, ST_HIT, 10'h010, 8'h3C, 3});
    rows.push_back('{OP_INSERT, 64'hAAAA, 10'h010, 8'h55, ST_HIT, 10'h010, 8'h00, 3});
    rows.push_back('{OP_LOOKUP, 64'hAAAA, 10'h010, 8'h00, ST_HIT, 10'h010, 8'h55, 3});
    foreach (rows[i]) begin
      run_req(1'b0, rows[i].op, rows[i].key, rows[i].hash, rows[i].data, got, st, idx, d, lat);
      n_cmp++;
      if (!got || st !== rows[i].st || idx !== rows[i].idx || d !== rows[i].d || lat !== rows[i].lat) begin
        n_fail++;
        $display("[TB] FAIL insert_lookup[%0d]: v=%0b st=%0d idx=%h d=%h lat=%0d, required st=%0d idx=%h d=%h lat=%0d",
                 i, got, st, idx, d, lat, rows[i].st, rows[i].idx, rows[i].d, rows[i].lat);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({tif.resp_valid, tif.resp_status, tif.resp_data, tif.resp_index} !== '0) begin
      n_fail++;
      $display("[TB] FAIL idle_outputs: v=%0b st=%0d d=%h idx=%h, required all 0",
               tif.resp_valid, tif.resp_status, tif.resp_data, tif.resp_index);
    end
  endtask

  // A, B, C share hash 0x3FF so B and C wrap to 0x000 and 0x001.
  task automatic test_collision_wrap();
    row_t rows[$];
    bit got; logic [1:0] st; logic [ADDR_W-1:0] idx; logic [DATA_W-1:0] d; int lat;
    rows.push_back('{OP_INSERT, 64'hA, 10'h3FF, 8'h11, ST_INS, 10'h3FF, 8'h00, 3});
    rows.push_back('{OP_INSERT, 64'hB, 10'h3FF, 8'h22, ST_INS, 10'h000, 8'h00, 5});
    rows.push_back('{OP_INSERT, 64'hC, 10'h3FF, 8'h33, ST_INS, 10'h001, 8'h00, 7});
    rows.push_back('{OP_LOOKUP, 64'hC, 10'h3FF, 8'h00, ST_HIT, 10'h001, 8'h33, 7});
    foreach (rows[i]) begin
      run_req(1'b0, rows[i].op, rows[i].key, rows[i].hash, rows[i].data, got, st, idx, d, lat);
      n_cmp++;
      if (!got || st !== rows[i].st || idx !== rows[i].idx || d !== rows[i].d || lat !== rows[i].lat) begin
        n_fail++;
        $display("[TB] FAIL collision_wrap[%0d]: v=%0b st=%0d idx=%h d=%h lat=%0d, required st=%0d idx=%h d=%h lat=%0d",
                 i, got, st, idx, d, lat, rows[i].st, rows[i].idx, rows[i].d, rows[i].lat);
      end
    end
  endtask

  // After deleting B, a lookup of B walks A, the tombstone, C and stops at
  // the empty slot 0x002 (k=3). D then reuses the tombstone at 0x000.
  task automatic test_delete_tomb();
    row_t rows[$];
    bit got; logic [1:0] st; logic [ADDR_W-1:0] idx; logic [DATA_W-1:0] d; int lat;
    rows.push_back('{OP_DELETE, 64'hB, 10'h3FF, 8'h00, ST_HIT,  10'h000, 8'h00, 5});
    rows.push_back('{OP_LOOKUP, 64'hB, 10'h3FF, 8'h00, ST_MISS, 10'h000, 8'h00, 9});
    rows.push_back('{OP_LOOKUP, 64'hC, 10'h3FF, 8'h00, ST_HIT,  10'h001, 8'h33, 7});
    rows.push_back('{OP_INSERT, 64'hD, 10'h3FF, 8'h44, ST_INS,  10'h000, 8'h00, 9});
    rows.push_back('{OP_LOOKUP, 64'hD, 10'h3FF, 8'h00, ST_HIT,  10'h000, 8'h44, 5});
    foreach (rows[i]) begin
      run_req(1'b0, rows[i].op, rows[i].key, rows[i].hash, rows[i].data, got, st, idx, d, lat);
      n_cmp++;
      if (!got || st !== rows[i].st || idx !== rows[i].idx || d !== rows[i].d || lat !== rows[i].lat) begin
        n_fail++;
        $display("[TB] FAIL delete_tomb[%0d]: v=%0b st=%0d idx=%h d=%h lat=%0d, required st=%0d idx=%h d=%h lat=%0d",
                 i, got, st, idx, d, lat, rows[i].st, rows[i].idx, rows[i].d, rows[i].lat);
      end
    end
  endtask

  task automatic test_full();
    row_t rows[$];
    bit got; logic [1:0] st; logic [ADDR_W-1:0] idx; logic [DATA_W-1:0] d; int lat;
    for (int i = 0; i < 4; i++)
      rows.push_back('{OP_INSERT, 64'hF000 + 64'(i), 10'h020, 8'(i + 1), ST_INS, 10'h020 + 10'(i), 8'h00, 3 + 2 * i});
    rows.push_back('{OP_INSERT, 64'hF004, 10'h020, 8'h99, ST_FULL, 10'h000, 8'h00, 9});
    rows.push_back('{OP_LOOKUP, 64'hF004, 10'h020, 8'h00, ST_MISS, 10'h000, 8'h00, 9});
    rows.push_back('{OP_LOOKUP, 64'hF003, 10'h020, 8'h00, ST_HIT,  10'h023, 8'h04, 9});
    foreach (rows[i]) begin
      run_req(1'b0, rows[i].op, rows[i].key, rows[i].hash, rows[i].data, got, st, idx, d, lat);
      n_cmp++;
      if (!got || st !== rows[i].st || idx !== rows[i].idx || d !== rows[i].d || lat !== rows[i].lat) begin
        n_fail++;
        $display("[TB] FAIL full[%0d]: v=%0b st=%0d idx=%h d=%h lat=%0d, required st=%0d idx=%h d=%h lat=%0d",
                 i, got, st, idx, d, lat, rows[i].st, rows[i].idx, rows[i].d, rows[i].lat);
      end
    end
  endtask

  task automatic test_reserved();
    bit got; logic [1:0] st; logic [ADDR_W-1:0] idx; logic [DATA_W-1:0] d; int lat;
    run_req(1'b0, OP_RSVD, 64'hAAAA, 10'h010, 8'h77, got, st, idx, d, lat);
    n_cmp++;
    if (!got || st !== ST_MISS || idx !== '0 || d !== '0 || lat !== 1) begin
      n_fail++;
      $display("[TB] FAIL reserved_op: v=%0b st=%0d idx=%h d=%h lat=%0d, required st=0 idx=0 d=0 lat=1",
               got, st, idx, d, lat);
    end
  endtask

  // Each pair issues its second request in the very cycle the first one
  // responds; the second must see the first one's write.
  task automatic test_back_to_back();
    row_t rows[$];
    bit got; logic [1:0] st; logic [ADDR_W-1:0] idx; logic [DATA_W-1:0] d; int lat;
    rows.push_back('{OP_LOOKUP, 64'hAAAA, 10'h010, 8'h00, ST_HIT,  10'h010, 8'h55, 3});
    rows.push_back('{OP_LOOKUP, 64'h1,    10'h005, 8'h00, ST_MISS, 10'h000, 8'h00, 3});
    rows.push_back('{OP_INSERT, 64'hE,    10'h200, 8'h77, ST_INS,  10'h200, 8'h00, 3});
    rows.push_back('{OP_LOOKUP, 64'hE,    10'h200, 8'h00, ST_HIT,  10'h200, 8'h77, 3});
    foreach (rows[i]) begin
      if (i % 2 == 1) begin
        n_cmp++;
        if (tif.req_ready !== 1'b1 || tif.resp_valid !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL b2b_ready[%0d]: ready=%0b resp_valid=%0b, required 1 1", i, tif.req_ready, tif.resp_valid);
        end
      end
      run_req(i % 2 == 1, rows[i].op, rows[i].key, rows[i].hash, rows[i].data, got, st, idx, d, lat);
      n_cmp++;
      if (!got || st !== rows[i].st || idx !== rows[i].idx || d !== rows[i].d || lat !== rows[i].lat) begin
        n_fail++;
        $display("[TB] FAIL back_to_back[%0d]: v=%0b st=%0d idx=%h d=%h lat=%0d, required st=%0d idx=%h d=%h lat=%0d",
                 i, got, st, idx, d, lat, rows[i].st, rows[i].idx, rows[i].d, rows[i].lat);
      end
    end
  endtask

  // Reset lands on the CHECK cycle of an INSERT into an empty slot.
  task automatic test_reset_mid_op();
    bit seen = 1'b0;
    int w = 0;
    bit got; logic [1:0] st; logic [ADDR_W-1:0] idx; logic [DATA_W-1:0] d; int lat;
    @(negedge clk);
    tif.req_valid = 1'b1; tif.req_op = OP_INSERT; tif.req_key = 64'hF00D;
    tif.req_hash = 10'h300; tif.req_data = 8'h99;
    @(negedge clk);
    tif.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    seen = seen | tif.resp_valid;
    rst = 1'b0;
    while (!tif.req_ready && w < 2000) begin
      @(negedge clk);
      seen = seen | tif.resp_valid;
      w++;
    end
    n_cmp++;
    if (seen !== 1'b0 || w !== 1024) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_op: resp_seen=%0b init_cycles=%0d, required 0 and 1024", seen, w);
    end
    run_req(1'b1, OP_LOOKUP, 64'hF00D, 10'h300, 8'h00, got, st, idx, d, lat);
    n_cmp++;
    if (!got || st !== ST_MISS || idx !== '0 || d !== '0 || lat !== 3) begin
      n_fail++;
      $display("[TB] FAIL lookup_after_reset: v=%0b st=%0d idx=%h d=%h lat=%0d, required st=0 idx=0 d=0 lat=3",
               got, st, idx, d, lat);
    end
  endtask

  // Random ops over a small key pool crowded around the wrap point so
  // collisions, tombstones and FULL all occur. The table is empty on entry.
  task automatic test_random();
    logic [KEY_W-1:0]  pool_key  [12];
    logic [ADDR_W-1:0] pool_hash [12];
    bit got; logic [1:0] st; logic [ADDR_W-1:0] idx; logic [DATA_W-1:0] d; int lat;
    logic [1:0] e_st; logic [ADDR_W-1:0] e_idx; logic [DATA_W-1:0] e_d; int e_lat;
    model_clear();
    for (int i = 0; i < 12; i++) begin
      pool_key[i]  = {$urandom, $urandom};
      pool_hash[i] = ADDR_W'(10'h3FD + 10'($urandom_range(0, 4)));
    end
    for (int n = 0; n < 200; n++) begin
      int r = $urandom_range(0, 9);
      int p = $urandom_range(0, 11);
      logic [1:0] op;
      logic [DATA_W-1:0] data = 8'($urandom);
      op = (r < 4) ? OP_INSERT : (r < 7) ? OP_LOOKUP : (r < 9) ? OP_DELETE : OP_RSVD;
      model_apply(op, pool_key[p], pool_hash[p], data, e_st, e_idx, e_d, e_lat);
      run_req($urandom_range(0, 1) == 1 && tif.resp_valid, op, pool_key[p], pool_hash[p], data,
              got, st, idx, d, lat);
      n_cmp++;
      if (!got || st !== e_st || idx !== e_idx || d !== e_d || lat !== e_lat) begin
        n_fail++;
        $display("[TB] FAIL random[%0d] op=%0d: v=%0b st=%0d idx=%h d=%h lat=%0d, required st=%0d idx=%h d=%h lat=%0d",
                 n, op, got, st, idx, d, lat, e_st, e_idx, e_d, e_lat);
      end
    end
  endtask

  initial begin
    tif.req_valid = 1'b0;
    tif.req_op    = '0;
    tif.req_key   = '0;
    tif.req_hash  = '0;
    tif.req_data  = '0;
    $display("[TB] name_hash_table bench start");
    test_reset();
    test_insert_lookup();
    test_collision_wrap();
    test_delete_tomb();
    test_full();
    test_reserved();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
